// File: rtl/des_ctrl_pkg.sv
// Shared types and constants for the iterative DES round control.
// The state enum, the round count and the one-position rotation schedule live here.
package des_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_OUT
  } state_t;

  localparam int DES_ROUNDS  = 16;
  localparam int ROUND_IDX_W = 4;

  // Bit (r-1) is set for the rounds that rotate by one position: 1, 2, 9 and 16.
  localparam logic [DES_ROUNDS-1:0] ONE_SHIFT_MASK = 16'h8103;

endpackage

// File: rtl/des_shift_schedule.sv
// Key schedule lookup: maps the current round and mode to the rotate enable and amount.
// Decrypt round 1 uses the unrotated PC-1 output, so it suppresses the rotate.
import des_ctrl_pkg::*;

module des_shift_schedule (
  input  logic [ROUND_IDX_W-1:0] round_idx,
  input  logic                   mode,
  output logic                   key_shift_en_raw,
  output logic                   shift_two
);

  always_comb begin
    key_shift_en_raw = 1'b1;
    shift_two        = ~ONE_SHIFT_MASK[round_idx];
    if (mode && (round_idx == '0)) begin
      key_shift_en_raw = 1'b0;
    end
  end

endmodule

// File: rtl/des_round_sequencer.sv
// Control FSM for the single-round DES engine: owns the round and cycle counters
// and decodes load, rotate, round-update and output-latch strobes for both directions.
import des_ctrl_pkg::*;

module des_round_sequencer #(
  parameter int ROUND_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   decrypt,
  output logic                   load_data,
  output logic                   load_key,
  output logic                   key_shift_en,
  output logic                   shift_two,
  output logic                   shift_right,
  output logic                   round_en,
  output logic [ROUND_IDX_W-1:0] round_idx,
  output logic                   out_load,
  output logic                   busy,
  output logic                   done
);

  localparam logic [3:0]             LAST_CYC = 4'(ROUND_CYCLES - 1);
  localparam logic [ROUND_IDX_W-1:0] LAST_IDX = ROUND_IDX_W'(DES_ROUNDS - 1);

  state_t                 state_q;
  logic [3:0]             cyc_q;
  logic [ROUND_IDX_W-1:0] idx_q;
  logic                   mode_q;
  logic                   done_q;

  logic in_round;
  logic first_cyc;
  logic last_cyc;
  logic ks_raw;
  logic two_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q  <= decrypt;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          idx_q   <= '0;
          cyc_q   <= '0;
          state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          if (cyc_q == LAST_CYC) begin
            cyc_q <= '0;
            if (idx_q == LAST_IDX) begin
              state_q <= ST_OUT;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        ST_OUT: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  des_shift_schedule u_sched (
    .round_idx        (idx_q),
    .mode             (mode_q),
    .key_shift_en_raw (ks_raw),
    .shift_two        (two_raw)
  );

  // All strobes are decoded from registered state only; inputs never reach outputs.
  assign in_round     = (state_q == ST_ROUND);
  assign first_cyc    = in_round && (cyc_q == '0);
  assign last_cyc     = in_round && (cyc_q == LAST_CYC);

  assign load_data    = (state_q == ST_LOAD);
  assign load_key     = (state_q == ST_LOAD);
  assign key_shift_en = first_cyc && ks_raw;
  assign shift_two    = key_shift_en && two_raw;
  assign round_en     = last_cyc;
  assign round_idx    = in_round ? idx_q : '0;
  assign out_load     = (state_q == ST_OUT);
  assign busy         = (state_q != ST_IDLE);
  assign shift_right  = busy && mode_q;
  assign done         = done_q;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Self-checking bench for des_round_sequencer with ROUND_CYCLES of 2 and 5,
// compared cycle by cycle against a timeline model of the DES round schedule.
module tb_des_round_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic decrypt = 1'b0;
  logic sel = 1'b0;

  int checks = 0;
  int failures = 0;

  logic start2, start5;
  assign start2 = start & ~sel;
  assign start5 = start & sel;

  logic       ld2, lk2, ks2, st2, sr2, re2, ol2, bz2, dn2;
  logic [3:0] ix2;
  logic       ld5, lk5, ks5, st5, sr5, re5, ol5, bz5, dn5;
  logic [3:0] ix5;

  always #5 clk = ~clk;

  des_round_sequencer #(.ROUND_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .decrypt(decrypt),
    .load_data(ld2), .load_key(lk2), .key_shift_en(ks2), .shift_two(st2),
    .shift_right(sr2), .round_en(re2), .round_idx(ix2), .out_load(ol2),
    .busy(bz2), .done(dn2)
  );

  des_round_sequencer #(.ROUND_CYCLES(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .decrypt(decrypt),
    .load_data(ld5), .load_key(lk5), .key_shift_en(ks5), .shift_two(st5),
    .shift_right(sr5), .round_en(re5), .round_idx(ix5), .out_load(ol5),
    .busy(bz5), .done(dn5)
  );

  // Packed view: 12 ld, 11 lk, 10 ks, 9 st (masked by ks), 8 sr, 7 re, 6:3 idx, 2 ol, 1 busy, 0 done.
  logic [12:0] obs2, obs5;
  assign obs2 = {ld2, lk2, ks2, ks2 & st2, sr2, re2, ix2, ol2, bz2, dn2};
  assign obs5 = {ld5, lk5, ks5, ks5 & st5, sr5, re5, ix5, ol5, bz5, dn5};

  function automatic bit is_one_shift(input int r);
    return (r == 1) || (r == 2) || (r == 9) || (r == 16);
  endfunction

  // Expected outputs n cycles after the LOAD cycle of an operation.
  function automatic logic [12:0] expect_vec(input int rc, input bit m, input int n);
    logic [12:0] e;
    int r, c;
    int last;
    e = '0;
    last = 16 * rc + 1;
    if (n == 0) begin
      e[12] = 1'b1; e[11] = 1'b1; e[8] = m; e[1] = 1'b1;
    end else if (n <= 16 * rc) begin
      r = (n - 1) / rc + 1;
      c = (n - 1) % rc;
      e[8] = m; e[1] = 1'b1;
      e[6:3] = 4'(r - 1);
      if (c == 0 && !(m && r == 1)) begin
        e[10] = 1'b1;
        e[9]  = !is_one_shift(r);
      end
      if (c == rc - 1) e[7] = 1'b1;
    end else if (n == last) begin
      e[2] = 1'b1; e[8] = m; e[1] = 1'b1;
    end else if (n == last + 1) begin
      e[0] = 1'b1;
    end
    return e;
  endfunction

  task automatic run_op(input bit s, input bit m, input bit pre, input bit noise,
                        input bit chain, input bit chain_m, input string tag);
    int rc, last, rot, exp_rot, rens;
    logic [12:0] o, e;
    rc = s ? 5 : 2;
    last = 16 * rc + 1;
    rot = 0; exp_rot = 0; rens = 0;
    sel = s;
    if (!pre) begin
      start = 1'b1; decrypt = m;
      @(negedge clk);
    end
    start = 1'b0;
    for (int n = 0; n <= last + 1; n++) begin
      o = s ? obs5 : obs2;
      e = expect_vec(rc, m, n);
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL %s cycle %0d: got %b expected %b", tag, n, o, e);
      end
      if (o[10]) rot += o[9] ? 2 : 1;
      if (e[10]) exp_rot += e[9] ? 2 : 1;
      if (o[7]) rens++;
      if (n <= last) begin
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        decrypt = 1'($urandom_range(0, 1));
      end else begin
        start = chain; decrypt = chain_m;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (rot !== exp_rot) begin
      failures++;
      $display("[TB] FAIL %s rotation_sum: got %0d expected %0d", tag, rot, exp_rot);
    end
    if (!m) begin
      checks++;
      if (rot !== 28) begin
        failures++;
        $display("[TB] FAIL %s encrypt_rotation_28: got %0d expected 28", tag, rot);
      end
    end
    checks++;
    if (rens !== 16) begin
      failures++;
      $display("[TB] FAIL %s round_en_count: got %0d expected 16", tag, rens);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs2 !== 13'd0 || obs5 !== 13'd0) begin
        failures++;
        $display("[TB] FAIL reset_hold: got %b/%b expected 0", obs2, obs5);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (obs2 !== 13'd0 || obs5 !== 13'd0) begin
        failures++;
        $display("[TB] FAIL idle_quiet: got %b/%b expected 0", obs2, obs5);
      end
    end
  endtask

  task automatic test_encrypt();
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "encrypt_rc2");
  endtask

  task automatic test_decrypt();
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "decrypt_rc2");
  endtask

  task automatic test_ignored_start();
    for (int k = 0; k < 3; k++)
      run_op(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 1'b0, "ignored_start");
  endtask

  task automatic test_back_to_back();
    bit m1, m2;
    m1 = 1'($urandom_range(0, 1));
    m2 = ~m1;
    run_op(1'b0, m1, 1'b0, 1'b0, 1'b1, m2, "b2b_first");
    run_op(1'b0, m2, 1'b1, 1'b0, 1'b0, 1'b0, "b2b_second");
  endtask

  task automatic test_mid_reset();
    logic [12:0] e;
    sel = 1'b0;
    start = 1'b1; decrypt = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= 13; n++) begin
      e = expect_vec(2, 1'b0, n);
      checks++;
      if (obs2 !== e) begin
        failures++;
        $display("[TB] FAIL midrst_pre cycle %0d: got %b expected %b", n, obs2, e);
      end
      if (n == 13) rst = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs2 !== 13'd0) begin
        failures++;
        $display("[TB] FAIL midrst_quiet cycle %0d: got %b expected 0", i, obs2);
      end
      @(negedge clk);
    end
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "after_midrst");
  endtask

  task automatic test_rc5();
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "encrypt_rc5");
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "decrypt_rc5");
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    test_rc5();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
